// File: rtl/decode_buffer_ctrl.sv
// In-order DEPTH-entry decode queue: payload visible one cycle after push, head held while raw_i is high.
// Backpressure: ready_pre_o drops when full or flushing and ignores ready_post_i.
module decode_buffer_ctrl #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       valid_pre_i,
    output logic                       ready_pre_o,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       raw_i,
    output logic                       valid_post_o,
    input  logic                       ready_post_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       we_o,
    output logic                       branch_valid_o,
    output logic [1:0]                 state_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [CNT_W-1:0]           stall_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        STALL  = 2'b10,
        FLUSH  = 2'b11
    } state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      count, count_nxt;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [CNT_W-1:0]   stall_cnt;
    logic               push, pop, stall_inc;

    // Gating with reset keeps we_o low while reset is held, even if fetch is presenting data.
    assign push      = valid_pre_i & ready_pre_o & ~flush_i & reset;
    assign pop       = valid_post_o & ready_post_i & ~flush_i;
    assign stall_inc = (count != '0) & raw_i & (state != FLUSH);

    always_comb begin
        count_nxt = count;
        if (flush_i)
            count_nxt = '0;
        else if (push && !pop)
            count_nxt = count + CW'(1);
        else if (pop && !push)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (stall_inc && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= data_i;
    end

    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = FLUSH;
        end else begin
            case (state)
                IDLE:    if (push) state_nxt = ACTIVE;
                ACTIVE:  if (count_nxt == '0) state_nxt = IDLE;
                         else if (raw_i)      state_nxt = STALL;
                STALL:   if (count_nxt == '0) state_nxt = IDLE;
                         else if (!raw_i)     state_nxt = ACTIVE;
                FLUSH:   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // STALL is a perf indicator only; issue gating uses the live raw_i.
    always_comb begin
        ready_pre_o    = (count != FULL) && (state != FLUSH);
        valid_post_o   = (count != '0) && !raw_i && (state != FLUSH);
        branch_valid_o = valid_post_o;
        we_o           = push;
        state_o        = state;
        count_o        = count;
        stall_cnt_o    = stall_cnt;
        data_o         = mem[rd_ptr];
    end

endmodule

// File: tb/tb_decode_buffer_ctrl.sv
// Randomised and directed bench for decode_buffer_ctrl; a queue-based reference model predicts every output.
module tb_decode_buffer_ctrl;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 5;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int SMAX   = (1 << CNT_W) - 1;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              flush_i = 1'b0, valid_pre_i = 1'b0, raw_i = 1'b0, ready_post_i = 1'b0;
    logic [DATA_W-1:0] data_i = '0;
    logic              ready_pre_o, valid_post_o, we_o, branch_valid_o;
    logic [DATA_W-1:0] data_o;
    logic [1:0]        state_o;
    logic [CW-1:0]     count_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    decode_buffer_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .flush_i(flush_i),
        .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o), .data_i(data_i),
        .raw_i(raw_i), .valid_post_o(valid_post_o), .ready_post_i(ready_post_i),
        .data_o(data_o), .we_o(we_o), .branch_valid_o(branch_valid_o),
        .state_o(state_o), .count_o(count_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy, named state, stall total, and the expected payload order.
    localparam logic [1:0] S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_STALL = 2'd2, S_FLUSH = 2'd3;
    int                m_cnt = 0;
    logic [1:0]        m_st = S_IDLE;
    int                m_stall = 0;
    logic [DATA_W-1:0] exp_q[$];

    function automatic bit m_ready();
        return (m_cnt != DEPTH) && (m_st != S_FLUSH);
    endfunction

    function automatic bit m_valid();
        return (m_cnt != 0) && !raw_i && (m_st != S_FLUSH);
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_cnt = 0; m_st = S_IDLE; m_stall = 0;
            exp_q.delete();
        end else begin
            bit push, pop;
            int nxt;
            push = valid_pre_i && m_ready() && !flush_i;
            pop  = m_valid() && ready_post_i && !flush_i;
            if (m_cnt != 0 && raw_i && m_st != S_FLUSH && m_stall < SMAX) m_stall++;
            if (flush_i) begin
                m_cnt = 0; m_st = S_FLUSH;
                exp_q.delete();
            end else begin
                nxt = m_cnt + int'(push) - int'(pop);
                if (push) exp_q.push_back(data_i);
                if (m_st == S_FLUSH)      m_st = S_IDLE;
                else if (m_st == S_IDLE)  m_st = push ? S_ACTIVE : S_IDLE;
                else if (nxt == 0)        m_st = S_IDLE;
                else if (raw_i)           m_st = S_STALL;
                else                      m_st = S_ACTIVE;
                m_cnt = nxt;
            end
        end
    end

    // Monitor: compares every output on the falling edge and retires the head on each real pop.
    always @(negedge clock) begin
        bit ev;
        ev = m_valid();
        chk("ready_pre_o",    ready_pre_o,    m_ready());
        chk("valid_post_o",   valid_post_o,   ev);
        chk("branch_valid_o", branch_valid_o, ev);
        chk("we_o",           we_o,           reset && valid_pre_i && m_ready() && !flush_i);
        chk("state_o",        state_o,        m_st);
        chk("count_o",        count_o,        m_cnt);
        chk("stall_cnt_o",    stall_cnt_o,    m_stall);
        if (ev) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty actual=valid required=empty_queue at %0t", $time);
            end else begin
                chk("data_o", data_o, exp_q[0]);
                if (ready_post_i && !flush_i) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic vp, input logic [63:0] d, input logic rp,
                       input logic rw, input logic fl);
        valid_pre_i = vp; data_i = d; ready_post_i = rp; raw_i = rw; flush_i = fl;
        @(posedge clock); #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        #1;
        chk("reset_ready_pre", ready_pre_o, 1'b1);
        chk("reset_count",     count_o,     '0);
        chk("reset_state",     state_o,     2'b00);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // Single entry through an empty queue.
        cyc(1, 64'hA, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);

        // Overfill with execute blocked, then drain in order.
        for (int i = 0; i < 5; i++) cyc(1, 64'h100 + 64'(i), 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0);

        // Full queue streaming with both sides active; pointers wrap.
        for (int i = 0; i < 4; i++) cyc(1, 64'h200 + 64'(i), 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 64'h300 + 64'(i), 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0);

        // RAW hold on a two-entry queue.
        cyc(1, 64'h400, 0, 0, 0);
        cyc(1, 64'h401, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);

        // Flush with simultaneous push and pop, then a back-to-back flush.
        for (int i = 0; i < 3; i++) cyc(1, 64'h500 + 64'(i), 0, 0, 0);
        cyc(1, 64'h5FF, 1, 0, 1);
        cyc(1, 64'h5FE, 1, 0, 0);
        cyc(1, 64'h5FD, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);

        // Asynchronous reset in the middle of a drain.
        cyc(1, 64'h600, 0, 1, 0);
        cyc(1, 64'h601, 0, 1, 0);
        valid_pre_i = 1'b1; ready_post_i = 1'b1; raw_i = 1'b0; flush_i = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_ready_pre",    ready_pre_o,    1'b1);
        chk("arst_valid_post",   valid_post_o,   1'b0);
        chk("arst_we",           we_o,           1'b0);
        chk("arst_branch_valid", branch_valid_o, 1'b0);
        chk("arst_state",        state_o,        2'b00);
        chk("arst_count",        count_o,        '0);
        chk("arst_stall_cnt",    stall_cnt_o,    '0);
        @(posedge clock); #1 reset = 1'b1;
        cyc(1, 64'h0DDBA11, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);

        // Randomised phases: balanced, filling with heavy RAW (saturates the counter), draining.
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(3) != 0, rnd64(), $urandom_range(2) != 0,
                $urandom_range(3) == 0, $urandom_range(24) == 0);
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(1) != 0, rnd64(), $urandom_range(4) == 0,
                $urandom_range(1) == 0, $urandom_range(60) == 0);
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(4) == 0, rnd64(), 1'b1,
                $urandom_range(5) == 0, $urandom_range(40) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
